calc_cmd_sequencer: RTL and testbench

//  Assembles decoded keyboard tokens into one calculator command: one operation letter,

---
 rtl/calc_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// Collects one operation token plus up to MAX_DIGITS decimal digits and issues them as a
// single command over a valid/ready handshake; malformed token streams raise err.
module calc_cmd_sequencer #(
  parameter int unsigned MAX_DIGITS     = 4,
  parameter int unsigned OPERAND_W      = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tok_valid,
  input  logic [3:0]           tok_digit,
  input  logic                 tok_is_number,
  input  logic                 tok_is_valid,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [1:0]           cmd_op,
  output logic [OPERAND_W-1:0] cmd_operand,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ErrInvalid = 2'd1;
  localparam logic [1:0] ErrNoOp    = 2'd2;
  localparam logic [1:0] ErrBusy    = 2'd3;

  typedef enum logic [1:0] {StIdle, StGetNum, StIssue} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [OPERAND_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [TmrW-1:0]      tmr_q, tmr_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (tok_valid) begin
          if (!tok_is_valid) begin
            err_d      = 1'b1;
            err_code_d = ErrInvalid;
          end else if (tok_is_number) begin
            err_d      = 1'b1;
            err_code_d = ErrNoOp;
          end else begin
            // Op codes 12..15 map onto 0..3 through the low two bits.
            op_d    = tok_digit[1:0];
            acc_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = StGetNum;
          end
        end
      end

      StGetNum: begin
        if (tok_valid) begin
          // A token always beats a timeout expiring in the same cycle.
          tmr_d = '0;
          if (!tok_is_valid) begin
            err_d      = 1'b1;
            err_code_d = ErrInvalid;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = StIdle;
          end else if (tok_is_number) begin
            acc_d = acc_q * OPERAND_W'(10) + OPERAND_W'(tok_digit);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(MAX_DIGITS - 1)) begin
              state_d = StIssue;
            end
          end else begin
            op_d  = tok_digit[1:0];
            acc_d = '0;
            cnt_d = '0;
          end
        end else if (cnt_q != '0) begin
          if (tmr_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
            tmr_d   = '0;
            state_d = StIssue;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end

      StIssue: begin
        if (tok_valid) begin
          err_d      = 1'b1;
          err_code_d = ErrBusy;
        end
        if (cmd_ready) begin
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign cmd_valid   = (state_q == StIssue);
  assign busy        = (state_q != StIdle);
  assign cmd_op      = op_q;
  assign cmd_operand = acc_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench: a table of complete commands plus hand-written handshake, error,
// timeout-race and reset sequences, all checked against hand-computed values.
module tb_calc_cmd_sequencer;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        tok_valid;
  logic [3:0]  tok_digit;
  logic        tok_is_number;
  logic        tok_is_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [13:0] cmd_operand;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  int n_vec = 0;
  int n_bad = 0;

  calc_cmd_sequencer #(
    .MAX_DIGITS    (4),
    .OPERAND_W     (14),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tok_valid    (tok_valid),
    .tok_digit    (tok_digit),
    .tok_is_number(tok_is_number),
    .tok_is_valid (tok_is_valid),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_operand  (cmd_operand),
    .busy         (busy),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  nd;
    logic [15:0] digits;
    logic [1:0]  exp_op;
    logic [13:0] exp_operand;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic num, input logic ok);
    tok_digit     = d;
    tok_is_number = num;
    tok_is_valid  = ok;
    tok_valid     = 1'b1;
    tick();
    tok_valid     = 1'b0;
  endtask

  // Expects no command for TO-1 idle edges after the last digit, then cmd_valid on edge TO.
  task automatic run_timeout(input string name);
    logic early;
    early = 1'b0;
    repeat (TO - 1) begin
      tick();
      if (cmd_valid) early = 1'b1;
    end
    check({name, " early"}, 32'(early), 0);
    tick();
    check({name, " valid"}, 32'(cmd_valid), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{op: 4'd12, nd: 3'd4, digits: 16'h1234, exp_op: 2'd0, exp_operand: 14'd1234};
    vecs[1] = '{op: 4'd14, nd: 3'd1, digits: 16'h7000, exp_op: 2'd2, exp_operand: 14'd7};
    vecs[2] = '{op: 4'd13, nd: 3'd2, digits: 16'h0500, exp_op: 2'd1, exp_operand: 14'd5};
    vecs[3] = '{op: 4'd15, nd: 3'd4, digits: 16'h9999, exp_op: 2'd3, exp_operand: 14'd9999};
    vecs[4] = '{op: 4'd15, nd: 3'd4, digits: 16'h0013, exp_op: 2'd3, exp_operand: 14'd13};
    vecs[5] = '{op: 4'd14, nd: 3'd3, digits: 16'h4200, exp_op: 2'd2, exp_operand: 14'd420};

    rst = 1'b1; tok_valid = 1'b0; tok_digit = '0; tok_is_number = 1'b0;
    tok_is_valid = 1'b0; cmd_ready = 1'b1;
    repeat (2) tick();
    check("rst cmd_valid", 32'(cmd_valid), 0);
    check("rst cmd_op", 32'(cmd_op), 0);
    check("rst cmd_operand", 32'(cmd_operand), 0);
    check("rst busy", 32'(busy), 0);
    check("rst err", 32'(err), 0);
    check("rst err_code", 32'(err_code), 0);
    rst = 1'b0;

    // Ungated token fields must be ignored.
    tok_digit = 4'd5; tok_is_number = 1'b1; tok_is_valid = 1'b1;
    tick();
    check("ignored tok err", 32'(err), 0);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].op, 1'b0, 1'b1);
      check($sformatf("v%0d busy", i), 32'(busy), 1);
      for (int k = 0; k < int'(vecs[i].nd); k++) begin
        check($sformatf("v%0d no early valid d%0d", i, k), 32'(cmd_valid), 0);
        send(vecs[i].digits[15-4*k -: 4], 1'b1, 1'b1);
      end
      if (vecs[i].nd == 3'd4) check($sformatf("v%0d valid", i), 32'(cmd_valid), 1);
      else run_timeout($sformatf("v%0d timeout", i));
      check($sformatf("v%0d op", i), 32'(cmd_op), 32'(vecs[i].exp_op));
      check($sformatf("v%0d operand", i), 32'(cmd_operand), 32'(vecs[i].exp_operand));
      tick();
      check($sformatf("v%0d valid low", i), 32'(cmd_valid), 0);
      check($sformatf("v%0d idle", i), 32'(busy), 0);
    end

    // Op with no digits never times out; an invalid char then aborts it.
    send(4'd14, 1'b0, 1'b1);
    repeat (TO + 10) tick();
    check("no-digit valid", 32'(cmd_valid), 0);
    check("no-digit busy", 32'(busy), 1);
    send(4'd3, 1'b0, 1'b0);
    check("abort err", 32'(err), 1);
    check("abort code", 32'(err_code), 1);
    check("abort idle", 32'(busy), 0);

    // Digit in IDLE, then invalid char mid-operand.
    send(4'd5, 1'b1, 1'b1);
    check("idle digit err", 32'(err), 1);
    check("idle digit code", 32'(err_code), 2);
    tick();
    check("err pulse ends", 32'(err), 0);
    check("err code held", 32'(err_code), 2);
    send(4'd13, 1'b0, 1'b1);
    send(4'd4, 1'b1, 1'b1);
    send(4'd3, 1'b0, 1'b0);
    check("bad char err", 32'(err), 1);
    check("bad char code", 32'(err_code), 1);
    check("bad char idle", 32'(busy), 0);
    repeat (TO + 5) tick();
    check("bad char no cmd", 32'(cmd_valid), 0);

    // Back-pressure: command held stable while ready is low.
    cmd_ready = 1'b0;
    send(4'd15, 1'b0, 1'b1);
    send(4'd0, 1'b1, 1'b1); send(4'd0, 1'b1, 1'b1);
    send(4'd1, 1'b1, 1'b1); send(4'd3, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold valid c%0d", c), 32'(cmd_valid), 1);
      check($sformatf("hold operand c%0d", c), 32'(cmd_operand), 13);
      tick();
    end
    check("hold op", 32'(cmd_op), 3);
    cmd_ready = 1'b1;
    tick();
    check("hold released", 32'(cmd_valid), 0);

    // Tokens during ISSUE are dropped; also when coinciding with the handshake.
    cmd_ready = 1'b0;
    send(4'd12, 1'b0, 1'b1);
    send(4'd1, 1'b1, 1'b1); send(4'd2, 1'b1, 1'b1);
    send(4'd3, 1'b1, 1'b1); send(4'd4, 1'b1, 1'b1);
    send(4'd9, 1'b1, 1'b1);
    check("issue tok err", 32'(err), 1);
    check("issue tok code", 32'(err_code), 3);
    check("issue tok valid", 32'(cmd_valid), 1);
    check("issue tok operand", 32'(cmd_operand), 1234);
    tick();
    check("issue err pulse ends", 32'(err), 0);
    cmd_ready = 1'b1;
    send(4'd9, 1'b1, 1'b1);
    check("race valid low", 32'(cmd_valid), 0);
    check("race idle", 32'(busy), 0);
    check("race err", 32'(err), 1);
    check("race code", 32'(err_code), 3);

    // Op replacement mid-operand.
    send(4'd13, 1'b0, 1'b1); send(4'd3, 1'b1, 1'b1);
    send(4'd12, 1'b0, 1'b1);
    check("replace no err", 32'(err), 0);
    send(4'd8, 1'b1, 1'b1);
    run_timeout("replace timeout");
    check("replace op", 32'(cmd_op), 0);
    check("replace operand", 32'(cmd_operand), 8);
    tick();

    // Token landing on the expiring timeout edge restarts the timer.
    send(4'd14, 1'b0, 1'b1); send(4'd1, 1'b1, 1'b1);
    repeat (TO - 1) tick();
    send(4'd2, 1'b1, 1'b1);
    check("tok beats timeout", 32'(cmd_valid), 0);
    run_timeout("restart timeout");
    check("restart operand", 32'(cmd_operand), 12);
    tick();

    // Reset mid-operand and during ISSUE with a live handshake.
    send(4'd12, 1'b0, 1'b1); send(4'd4, 1'b1, 1'b1); send(4'd2, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst getnum busy", 32'(busy), 0);
    check("rst getnum operand", 32'(cmd_operand), 0);
    cmd_ready = 1'b0;
    send(4'd12, 1'b0, 1'b1);
    send(4'd1, 1'b1, 1'b1); send(4'd2, 1'b1, 1'b1);
    send(4'd3, 1'b1, 1'b1); send(4'd4, 1'b1, 1'b1);
    cmd_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst issue valid", 32'(cmd_valid), 0);
    check("rst issue busy", 32'(busy), 0);
    send(4'd13, 1'b0, 1'b1); send(4'd1, 1'b1, 1'b1);
    run_timeout("post-rst timeout");
    check("post-rst op", 32'(cmd_op), 1);
    check("post-rst operand", 32'(cmd_operand), 1);
    tick();
    check("post-rst done", 32'(cmd_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
